// File: rtl/load_store_unit_pkg.sv
// Shared types and constants for the load/store unit.
// Holds FSM encoding, memory size and big-endian byte offsets.
package load_store_unit_pkg;

  localparam int LSU_MEM_BYTES = 128;
  localparam int LSU_ADDR_W    = 7;

  localparam int OFF_HI = 0;
  localparam int OFF_LO = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HI   = 2'd1,
    ST_LO   = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/load_store_unit_req_check.sv
// Request validity check for the load/store unit.
// A request needs exactly one op and room for two bytes.
module lsu_req_check #(
  parameter int MEM_BYTES = 128
) (
  input  logic        rd,
  input  logic        wr,
  input  logic [15:0] addr,
  output logic        ok,
  output logic        err
);

  logic range_bad;

  assign range_bad = addr > 16'(MEM_BYTES - 2);
  assign ok        = !range_bad && (rd ^ wr);
  assign err       = !ok;

endmodule

// File: rtl/load_store_unit.sv
// 16-bit load/store unit over a byte-wide memory.
// Big-endian: high byte at Address, low byte at Address+1.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int MEM_BYTES = LSU_MEM_BYTES,
  parameter int ADDR_W    = LSU_ADDR_W
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              ReqValid,
  output logic              ReqReady,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [15:0]       Address,
  input  logic [15:0]       WriteData,
  output logic              RespValid,
  output logic [15:0]       ReadData,
  output logic              Error,
  output logic [ADDR_W-1:0] ByteAddr,
  output logic [7:0]        ByteWData,
  output logic              ByteWe,
  output logic              ByteRe,
  input  logic [7:0]        ByteRData
);

  lsu_state_e        state;
  lsu_state_e        state_n;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       wdata_q;
  logic              wr_q;
  logic              err_q;
  logic [15:0]       rdata_q;
  logic              req_ok;
  logic              req_err;
  logic              accept;

  lsu_req_check #(
    .MEM_BYTES(MEM_BYTES)
  ) u_check (
    .rd  (MemRead),
    .wr  (MemWrite),
    .addr(Address),
    .ok  (req_ok),
    .err (req_err)
  );

  assign ReqReady = (state == ST_IDLE);
  assign accept   = ReqValid && ReqReady;
  assign ReadData = rdata_q;

  always_ff @(posedge Clock) begin
    if (Reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE: if (accept) state_n = req_ok ? ST_HI : ST_DONE;
      ST_HI:   state_n = ST_LO;
      ST_LO:   state_n = ST_DONE;
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else if (accept) begin
      addr_q  <= Address[ADDR_W-1:0];
      wdata_q <= WriteData;
      wr_q    <= MemWrite;
      err_q   <= req_err;
    end else begin
      // Load bytes land at the end of their own access cycle.
      if (state == ST_HI && !wr_q) rdata_q[15:8] <= ByteRData;
      if (state == ST_LO && !wr_q) rdata_q[7:0]  <= ByteRData;
    end
  end

  always_comb begin
    ByteAddr  = '0;
    ByteWData = '0;
    ByteWe    = 1'b0;
    ByteRe    = 1'b0;
    RespValid = 1'b0;
    Error     = 1'b0;
    unique case (state)
      ST_HI: begin
        ByteAddr  = addr_q + ADDR_W'(OFF_HI);
        ByteWe    = wr_q;
        ByteRe    = !wr_q;
        ByteWData = wr_q ? wdata_q[15:8] : 8'h00;
      end
      ST_LO: begin
        ByteAddr  = addr_q + ADDR_W'(OFF_LO);
        ByteWe    = wr_q;
        ByteRe    = !wr_q;
        ByteWData = wr_q ? wdata_q[7:0] : 8'h00;
      end
      ST_DONE: begin
        RespValid = 1'b1;
        Error     = err_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit with a transaction-level model.
// Directed cases pin the model with literal expectations.
module tb_load_store_unit;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        ReqValid;
  logic        ReqReady;
  logic        MemRead;
  logic        MemWrite;
  logic [15:0] Address;
  logic [15:0] WriteData;
  logic        RespValid;
  logic [15:0] ReadData;
  logic        Error;
  logic [6:0]  ByteAddr;
  logic [7:0]  ByteWData;
  logic        ByteWe;
  logic        ByteRe;
  logic [7:0]  ByteRData;

  load_store_unit #(
    .MEM_BYTES(128),
    .ADDR_W   (7)
  ) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .ReqValid (ReqValid),
    .ReqReady (ReqReady),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .Address  (Address),
    .WriteData(WriteData),
    .RespValid(RespValid),
    .ReadData (ReadData),
    .Error    (Error),
    .ByteAddr (ByteAddr),
    .ByteWData(ByteWData),
    .ByteWe   (ByteWe),
    .ByteRe   (ByteRe),
    .ByteRData(ByteRData)
  );

  always #5 Clock = ~Clock;

  logic [7:0] dut_mem [128];
  logic [7:0] ref_mem [128];

  assign ByteRData = dut_mem[ByteAddr];

  always @(posedge Clock) begin
    if (ByteWe) dut_mem[ByteAddr] <= ByteWData;
  end

  int checks = 0;
  int errors = 0;

  int          t = 0;
  bit          have = 0;
  int          acc_t;
  int          last;
  int          a;
  bit          a_wr;
  bit          a_err;
  logic [15:0] a_wd;
  logic [15:0] rd_model = 16'h0000;

  function automatic void chk(string n, logic [31:0] act,
                              logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endfunction

  function automatic bit model_busy();
    return have && (t - acc_t) <= last;
  endfunction

  task automatic check_cycle();
    int p;
    bit hi, lo, erv, ldp;
    p   = t - acc_t;
    erv = have && p == last;
    hi  = have && !a_err && p == 1;
    lo  = have && !a_err && p == 2;
    ldp = (hi || lo) && !a_wr;
    if (erv && !a_err && !a_wr)
      rd_model = {ref_mem[a], ref_mem[a+1]};
    chk("ReqReady", 32'(ReqReady), 32'(!model_busy()));
    chk("RespValid", 32'(RespValid), 32'(erv));
    if (erv) chk("Error", 32'(Error), 32'(a_err));
    chk("ByteWe", 32'(ByteWe), 32'((hi || lo) && a_wr));
    chk("ByteRe", 32'(ByteRe), 32'(ldp));
    if (hi) chk("ByteAddr_hi", 32'(ByteAddr), 32'(a));
    if (lo) chk("ByteAddr_lo", 32'(ByteAddr), 32'(a + 1));
    if (hi && a_wr) chk("ByteWData_hi", 32'(ByteWData), 32'(a_wd[15:8]));
    if (lo && a_wr) chk("ByteWData_lo", 32'(ByteWData), 32'(a_wd[7:0]));
    if (!ldp) chk("ReadData", 32'(ReadData), 32'(rd_model));
  endtask

  task automatic step(input bit rst, input bit rv, input bit rd,
                      input bit wr, input logic [15:0] ad,
                      input logic [15:0] wd);
    Reset     = rst;
    ReqValid  = rv;
    MemRead   = rd;
    MemWrite  = wr;
    Address   = ad;
    WriteData = wd;
    if (rst) begin
      have     = 0;
      rd_model = 16'h0000;
    end else if (rv && !model_busy()) begin
      have  = 1;
      acc_t = t;
      a_wr  = wr;
      a_err = (ad > 16'd126) || (rd == wr);
      a     = int'(ad[6:0]);
      a_wd  = wd;
      last  = a_err ? 1 : 3;
      if (!a_err && wr) begin
        ref_mem[a]   = wd[15:8];
        ref_mem[a+1] = wd[7:0];
      end
    end
    @(posedge Clock);
    t++;
    @(negedge Clock);
    check_cycle();
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 16'h0, 16'h0);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) begin
      dut_mem[i] = 8'($urandom);
      ref_mem[i] = dut_mem[i];
    end
    step(1, 0, 0, 0, 16'h0, 16'h0);
    step(1, 1, 1, 0, 16'h10, 16'h0);
    chk("rst_ready", 32'(ReqReady), 32'd1);
    chk("rst_resp", 32'(RespValid), 32'd0);
    chk("rst_rdata", 32'(ReadData), 32'h0);
    chk("rst_addr", 32'(ByteAddr), 32'h0);
    chk("rst_wdata", 32'(ByteWData), 32'h0);
    chk("rst_strobes", 32'({ByteWe, ByteRe}), 32'h0);

    step(0, 1, 0, 1, 16'h0010, 16'hBEEF);
    chk("st_hi_we", 32'(ByteWe), 32'd1);
    chk("st_hi_addr", 32'(ByteAddr), 32'h10);
    chk("st_hi_data", 32'(ByteWData), 32'hBE);
    idle();
    chk("st_lo_addr", 32'(ByteAddr), 32'h11);
    chk("st_lo_data", 32'(ByteWData), 32'hEF);
    idle();
    chk("st_resp", 32'(RespValid), 32'd1);
    chk("st_err", 32'(Error), 32'd0);
    idle();
    chk("st_mem_hi", 32'(dut_mem[16]), 32'hBE);
    chk("st_mem_lo", 32'(dut_mem[17]), 32'hEF);

    step(0, 1, 1, 0, 16'h0010, 16'h0);
    idle();
    idle();
    chk("ld_resp", 32'(RespValid), 32'd1);
    chk("ld_data", 32'(ReadData), 32'hBEEF);
    idle();

    step(0, 1, 1, 1, 16'h0010, 16'h1234);
    chk("rw_resp", 32'(RespValid), 32'd1);
    chk("rw_err", 32'(Error), 32'd1);
    chk("rw_strobes", 32'({ByteWe, ByteRe}), 32'h0);
    chk("rw_rdata", 32'(ReadData), 32'hBEEF);
    idle();

    step(0, 1, 1, 0, 16'h007F, 16'h0);
    chk("oob_resp", 32'(RespValid), 32'd1);
    chk("oob_err", 32'(Error), 32'd1);
    chk("oob_strobes", 32'({ByteWe, ByteRe}), 32'h0);
    idle();

    step(0, 1, 1, 0, 16'h007E, 16'h0);
    chk("edge_re", 32'(ByteRe), 32'd1);
    idle();
    idle();
    chk("edge_resp", 32'(RespValid), 32'd1);
    chk("edge_err", 32'(Error), 32'd0);
    idle();

    step(0, 1, 0, 1, 16'h0020, 16'hA5C3);
    idle();
    step(1, 0, 0, 0, 16'h0, 16'h0);
    chk("abort_resp", 32'(RespValid), 32'd0);
    chk("abort_ready", 32'(ReqReady), 32'd1);
    idle();
    chk("abort_nopulse", 32'(RespValid), 32'd0);
    ref_mem[32] = dut_mem[32];
    ref_mem[33] = dut_mem[33];

    for (int i = 0; i < 800; i++) begin
      bit          rv, rd, wr;
      int          op;
      logic [15:0] ad;
      rv = $urandom_range(0, 9) < 7;
      op = $urandom_range(0, 9);
      rd = (op == 0) || (op >= 2 && op <= 5);
      wr = (op == 0) || (op >= 6);
      case ($urandom_range(0, 9))
        0:       ad = 16'($urandom);
        1:       ad = 16'd126;
        default: ad = 16'($urandom_range(0, 127));
      endcase
      step(0, rv, rd, wr, ad, 16'($urandom));
    end
    idle();
    idle();
    idle();
    idle();
    for (int i = 0; i < 128; i++)
      chk("mem_final", 32'(dut_mem[i]), 32'(ref_mem[i]));

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
